sample_sequencer_mc: RTL and testbench
======================================

Name: sample_sequencer_mc

Overview:
Parametrised multi-channel sampling sequencer for the control loop. It owns the sample-period timer internally, so no external base timer is needed. Each period it launches N_CH sensor acquisitions in parallel, waits for all of them, pulses a per-channel hold strobe, then runs the PID block once per channel in sequence. It supports single-shot and continuous modes, handshake timeouts, abort, and period-overrun detection.

Parameters:
N_CH, 2, number of sensor/PID channels (1..8)
PER_W, 16, width of the period counter and of the period input
TO_W, 12, width of the handshake timeout counter and of the timeout input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stp  in  1  start request; sampled only in IDLE
abrt  in  1  synchronous abort; returns to IDLE from any state
cont  in  1  1 = continuous periods, 0 = single period; sampled at end of each period
period  in  PER_W  sample period in clk cycles; 0 is treated as 1
timeout  in  TO_W  maximum wait cycles per handshake; 0 disables the timeout
eoSEN  in  N_CH  per-channel sensor done (pulse or level)
eoPID  in  1  PID done for the current channel
stSEN  out  N_CH  sensor start, one-cycle pulse on all bits
h  out  N_CH  hold/latch strobe, one-cycle pulse on all bits
stPID  out  1  PID start, one-cycle pulse per channel
ch_idx  out  clog2(N_CH) (minimum 1)  channel being processed by the PID
ena  out  1  high in every non-IDLE state
eop  out  1  high only in IDLE
err  out  1  sticky timeout error
err_code  out  2  00 none, 01 sensor timeout, 10 PID timeout
ovr  out  1  sticky period overrun

Behaviour:
- Reset: state = IDLE; counters, done register, ch_idx, err, err_code and ovr are all 0. Outputs are then stSEN=0, h=0, stPID=0, ena=0, eop=1.
- Registered state. stSEN, h, stPID, ena and eop are decoded from state only.
- States:
  - IDLE: if stp=1, clear err, err_code and ovr, then go to LAUNCH. Otherwise stay.
  - LAUNCH (1 cycle): stSEN = all ones. Period counter cnt := 0. Sensor done register := 0. Go to WAIT_SEN.
  - WAIT_SEN: done |= eoSEN each cycle. When done is all ones (including the current cycle's eoSEN), go to HOLD. On timeout: err=1, err_code=01, go to IDLE.
  - HOLD (1 cycle): h = all ones. ch_idx := 0. Go to START_PID.
  - START_PID (1 cycle): stPID=1. Go to WAIT_PID.
  - WAIT_PID: on eoPID=1, if ch_idx = N_CH-1 go to WAIT_PER; otherwise ch_idx++ and go to START_PID. On timeout: err=1, err_code=10, go to IDLE.
  - WAIT_PER: stay until the period ends. At the end, go to LAUNCH if cont=1, else IDLE.
- Period counter:
  - Increments every non-IDLE cycle after LAUNCH.
  - Saturates at max(period,1)-1 and sets per_hit.
  - The period ends in the first WAIT_PER cycle where cnt = max(period,1)-1.
  - In continuous mode without overrun, successive LAUNCH cycles are exactly max(period,1) clocks apart.
- Overrun:
  - If per_hit was set before the first WAIT_PER cycle, set ovr. WAIT_PER then lasts exactly 1 cycle.
  - Sequencing continues; ovr is not an error.
  - Minimum sequence length is 4+2*N_CH cycles.
- Timeout counter:
  - Cleared on entry to WAIT_SEN and to each WAIT_PID.
  - Fires when the wait has lasted `timeout` cycles without completion.
  - A completion in the same cycle as the timeout wins (no error).
- abrt:
  - Has priority over every transition. Any non-IDLE state goes to IDLE on the next edge.
  - err and ovr are unchanged.
  - Outputs in the abort cycle are still those of the current state.
- stp is ignored outside IDLE. cont and period changes take effect only at the next LAUNCH or period end; period is sampled in LAUNCH.
- eoSEN bits arriving in LAUNCH are captured. Extra eoSEN pulses after done is full are ignored. eoPID outside WAIT_PID is ignored.
- Asynchronous rst mid-sequence: immediate return to reset values; no pulses complete.

Test Plan:
1. N_CH=2, period=40, cont=0. stp pulse; eoSEN=01 at +3, eoSEN=10 at +5; eoPID 2 cycles after each stPID -> stSEN=11 for 1 cycle, h=11 once, stPID pulses with ch_idx 0 then 1, eop returns to 1 exactly 40 cycles after LAUNCH, ovr=0, err=0.
2. Same setup with cont=1 for 3 periods -> LAUNCH cycles spaced exactly 40 clocks apart. Set cont=0 during period 3 -> IDLE after period 3.
3. timeout=8, eoSEN bit1 never asserted -> 8 cycles into WAIT_SEN: err=1, err_code=01, eop=1. A following stp clears err.
4. period=10, N_CH=2, eoPID delayed 6 cycles each -> ovr=1, WAIT_PER lasts 1 cycle, next LAUNCH follows immediately, err=0.
5. abrt asserted during WAIT_PID with ch_idx=1 -> IDLE next cycle, no further stPID, err unchanged.
6. eoPID arriving on the same cycle the timeout expires -> no error, sequence proceeds. Separately, rst asserted mid-WAIT_SEN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sample_sequencer_mc.sv
// Multi-channel sampling sequencer: launches N_CH sensor acquisitions per period,
// waits for all of them, strobes hold, then runs the PID once per channel.
module sample_sequencer_mc #(
  parameter  int N_CH  = 2,
  parameter  int PER_W = 16,
  parameter  int TO_W  = 12,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stp,
  input  logic             abrt,
  input  logic             cont,
  input  logic [PER_W-1:0] period,
  input  logic [TO_W-1:0]  timeout,
  input  logic [N_CH-1:0]  eoSEN,
  input  logic             eoPID,
  output logic [N_CH-1:0]  stSEN,
  output logic [N_CH-1:0]  h,
  output logic             stPID,
  output logic [CH_W-1:0]  ch_idx,
  output logic             ena,
  output logic             eop,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             ovr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_SEN, S_HOLD, S_START_PID, S_WAIT_PID, S_WAIT_PER
  } state_e;

  state_e           state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_m1_q, per_m1_d;
  logic             per_hit_q, per_hit_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             ovr_q, ovr_d;
  logic             to_fire;

  assign to_fire = (timeout != '0) && (tcnt_q == timeout - TO_W'(1));

  always_comb begin
    // NOTE: every signal gets its default first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_m1_d   = per_m1_q;
    per_hit_d  = per_hit_q;
    tcnt_d     = tcnt_q;
    done_d     = done_q;
    ch_idx_d   = ch_idx_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ovr_d      = ovr_q;

    if (state_q != S_IDLE && state_q != S_LAUNCH) begin
      cnt_d     = (cnt_q == per_m1_q) ? cnt_q : cnt_q + PER_W'(1);
      per_hit_d = per_hit_q | (cnt_q == per_m1_q);
      tcnt_d    = tcnt_q + TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (stp) begin
          err_d      = 1'b0;
          err_code_d = 2'b00;
          ovr_d      = 1'b0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // LAUNCH is cycle 0 of the period, so the counter already reads 1 on the next cycle.
        per_m1_d  = (period == '0) ? '0 : period - PER_W'(1);
        cnt_d     = (period > PER_W'(1)) ? PER_W'(1) : '0;
        per_hit_d = 1'b0;
        tcnt_d    = '0;
        done_d    = eoSEN;
        state_d   = S_WAIT_SEN;
      end
      S_WAIT_SEN: begin
        done_d = done_q | eoSEN;
        if (&done_d) begin
          state_d = S_HOLD;
        end else if (to_fire) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_IDLE;
        end
      end
      S_HOLD: begin
        ch_idx_d = '0;
        state_d  = S_START_PID;
      end
      S_START_PID: begin
        tcnt_d  = '0;
        state_d = S_WAIT_PID;
      end
      S_WAIT_PID: begin
        if (eoPID) begin
          if (ch_idx_q == CH_W'(N_CH - 1)) begin
            state_d = S_WAIT_PER;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            state_d  = S_START_PID;
          end
        end else if (to_fire) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end
      end
      S_WAIT_PER: begin
        // A counter that saturated before this cycle means the work overran the period.
        if (cnt_q == per_m1_q) begin
          if (per_hit_q) ovr_d = 1'b1;
          state_d = cont ? S_LAUNCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abrt) begin
      state_d    = S_IDLE;
      err_d      = err_q;
      err_code_d = err_code_q;
      ovr_d      = ovr_q;
    end
  end

  // NOTE: registers update with non-blocking assignments so every one sees the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      per_m1_q   <= '0;
      per_hit_q  <= 1'b0;
      tcnt_q     <= '0;
      done_q     <= '0;
      ch_idx_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_m1_q   <= per_m1_d;
      per_hit_q  <= per_hit_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
      ch_idx_q   <= ch_idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      ovr_q      <= ovr_d;
    end
  end

  assign stSEN    = {N_CH{state_q == S_LAUNCH}};
  assign h        = {N_CH{state_q == S_HOLD}};
  assign stPID    = (state_q == S_START_PID);
  assign ena      = (state_q != S_IDLE);
  assign eop      = (state_q == S_IDLE);
  assign ch_idx   = ch_idx_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_sample_sequencer_mc.sv
// Bench for sample_sequencer_mc: reactive sensor/PID responders, event timelines
// compared against an arithmetic per-period timing model.
module tb_sample_sequencer_mc;
  localparam int N_CH   = 2;
  localparam int PER_W  = 16;
  localparam int TO_W   = 12;
  localparam int CH_W   = 1;
  localparam int BUDGET = 1500;
  localparam int NEVER  = 1000000;

  logic             clk = 1'b0;
  logic             rst, stp, abrt, cont, eoPID;
  logic [PER_W-1:0] period;
  logic [TO_W-1:0]  timeout;
  logic [N_CH-1:0]  eoSEN, stSEN, h;
  logic             stPID, ena, eop, err, ovr;
  logic [CH_W-1:0]  ch_idx;
  logic [1:0]       err_code;

  sample_sequencer_mc #(.N_CH(N_CH), .PER_W(PER_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .stp(stp), .abrt(abrt), .cont(cont), .period(period),
    .timeout(timeout), .eoSEN(eoSEN), .eoPID(eoPID), .stSEN(stSEN), .h(h),
    .stPID(stPID), .ch_idx(ch_idx), .ena(ena), .eop(eop), .err(err),
    .err_code(err_code), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int cfg_period, cfg_tmo, cfg_nper, cfg_cut_rel;
  bit cfg_is_rst;
  int sdel [N_CH];
  int pdel [N_CH];

  int exp_launch[$], exp_h[$], exp_pid[$], exp_pch[$];
  int obs_launch[$], obs_h[$], obs_pid[$], obs_pch[$];
  int exp_idle, exp_err, exp_code, exp_ovr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int per, input int tmo, input int nper, input int s0, input int s1,
                         input int p0, input int p1, input int cut, input bit is_rst);
    cfg_period = per; cfg_tmo = tmo; cfg_nper = nper;
    sdel[0] = s0; sdel[1] = s1; pdel[0] = p0; pdel[1] = p1;
    cfg_cut_rel = cut; cfg_is_rst = is_rst;
  endtask

  // Timing model: each period is laid out from the sensor and PID delays with plain arithmetic.
  task automatic build_model(input int base);
    int p_len, t, cs, x, fin, err_cyc, ovr_cyc, cut;
    exp_launch.delete(); exp_h.delete(); exp_pid.delete(); exp_pch.delete();
    p_len = (cfg_period < 1) ? 1 : cfg_period;
    t = base; err_cyc = -1; ovr_cyc = -1; exp_code = 0;
    for (int k = 0; k < cfg_nper; k++) begin
      exp_launch.push_back(t);
      cs = 1;
      for (int i = 0; i < N_CH; i++) begin
        if (sdel[i] < 0) cs = NEVER;
        else if (sdel[i] > cs) cs = sdel[i];
      end
      if (cfg_tmo != 0 && cs > cfg_tmo) begin
        err_cyc = t + cfg_tmo; exp_code = 1;
        break;
      end
      exp_h.push_back(t + cs + 1);
      x = t + cs + 2;
      for (int c = 0; c < N_CH; c++) begin
        exp_pid.push_back(x); exp_pch.push_back(c);
        if (cfg_tmo != 0 && pdel[c] > cfg_tmo) begin
          err_cyc = x + cfg_tmo; exp_code = 2;
          break;
        end
        x = x + pdel[c] + 1;
      end
      if (err_cyc >= 0) break;
      if (x - t <= p_len - 1) begin
        fin = t + p_len - 1;
      end else begin
        fin = x;
        if (ovr_cyc < 0) ovr_cyc = fin;
      end
      t = fin + 1;
    end
    exp_err  = (err_cyc >= 0) ? 1 : 0;
    exp_idle = (err_cyc >= 0) ? err_cyc + 1 : t;
    cut = (cfg_cut_rel >= 0) ? base + cfg_cut_rel : NEVER;
    if (cut < exp_idle) begin
      exp_idle = cut + 1; exp_err = 0; exp_code = 0;
      while (exp_launch.size() > 0 && exp_launch[$] > cut) void'(exp_launch.pop_back());
      while (exp_h.size() > 0 && exp_h[$] > cut) void'(exp_h.pop_back());
      while (exp_pid.size() > 0 && exp_pid[$] > cut) begin
        void'(exp_pid.pop_back()); void'(exp_pch.pop_back());
      end
    end
    exp_ovr = (ovr_cyc >= 0 && ovr_cyc < cut) ? 1 : 0;
  endtask

  task automatic run_seq(input string tag);
    int base, idle_seen, sen_base, pid_base, pid_ch, pid_n, launches, glitches, tail;
    bit done, prev_eop, rst_hit;
    obs_launch.delete(); obs_h.delete(); obs_pid.delete(); obs_pch.delete();
    period  = PER_W'(cfg_period);
    timeout = TO_W'(cfg_tmo);
    cont    = (cfg_nper > 1);
    @(negedge clk); cyc++;
    stp  = 1'b1;
    base = cyc + 1;
    build_model(base);
    sen_base = -1; pid_base = -1; pid_ch = 0; pid_n = 0; launches = 0; glitches = 0;
    idle_seen = -1; tail = 0; done = 1'b0; prev_eop = 1'b1; rst_hit = 1'b0;
    for (int k = 0; k < BUDGET && !done; k++) begin
      @(negedge clk); cyc++;
      stp = 1'b0;
      if (stSEN == '1) begin
        obs_launch.push_back(cyc); sen_base = cyc; pid_n = 0; launches++;
        if (launches == 1) begin
          check({tag, "/err_at_launch"}, err, 0);
          check({tag, "/ovr_at_launch"}, ovr, 0);
        end
      end else if (stSEN != '0) glitches++;
      if (h == '1) obs_h.push_back(cyc);
      else if (h != '0) glitches++;
      if (stPID) begin
        obs_pid.push_back(cyc); obs_pch.push_back(int'(ch_idx));
        pid_base = cyc; pid_ch = (pid_n < N_CH) ? pid_n : N_CH - 1; pid_n++;
      end
      if (ena === eop) glitches++;
      if (eop && !prev_eop && idle_seen < 0) idle_seen = cyc;
      prev_eop = eop;
      for (int i = 0; i < N_CH; i++)
        eoSEN[i] = (sen_base >= 0 && sdel[i] >= 0 && cyc - sen_base == sdel[i]);
      eoPID = (pid_base >= 0 && cyc - pid_base == pdel[pid_ch]);
      cont  = (launches < cfg_nper);
      abrt  = (!cfg_is_rst && cfg_cut_rel >= 0 && cyc == base + cfg_cut_rel);
      if (cfg_is_rst && cyc == base + cfg_cut_rel) begin
        check({tag, "/ovr_before_rst"}, ovr, exp_ovr);
        check({tag, "/ena_before_rst"}, ena, 1);
        #2 rst = 1'b1;
        #1;
        check({tag, "/rst_stSEN"}, stSEN, 0);
        check({tag, "/rst_h"}, h, 0);
        check({tag, "/rst_stPID"}, stPID, 0);
        check({tag, "/rst_ena"}, ena, 0);
        check({tag, "/rst_eop"}, eop, 1);
        check({tag, "/rst_ovr"}, ovr, 0);
        check({tag, "/rst_err"}, {err, err_code}, 0);
        check({tag, "/rst_ch_idx"}, ch_idx, 0);
        eoSEN = '0; eoPID = 1'b0;
        @(negedge clk); cyc++;
        rst = 1'b0;
        rst_hit = 1'b1; done = 1'b1;
      end
      if (idle_seen >= 0) begin
        tail++;
        if (tail > 4) done = 1'b1;
      end
    end
    eoSEN = '0; eoPID = 1'b0; abrt = 1'b0;
    if (!rst_hit) begin
      if (!done) check({tag, "/reached_idle"}, 0, 1);
      check({tag, "/n_launch"}, obs_launch.size(), exp_launch.size());
      for (int i = 0; i < exp_launch.size() && i < obs_launch.size(); i++)
        check($sformatf("%s/launch%0d", tag, i), obs_launch[i] - base, exp_launch[i] - base);
      check({tag, "/n_hold"}, obs_h.size(), exp_h.size());
      for (int i = 0; i < exp_h.size() && i < obs_h.size(); i++)
        check($sformatf("%s/hold%0d", tag, i), obs_h[i] - base, exp_h[i] - base);
      check({tag, "/n_stpid"}, obs_pid.size(), exp_pid.size());
      for (int i = 0; i < exp_pid.size() && i < obs_pid.size(); i++) begin
        check($sformatf("%s/stpid%0d", tag, i), obs_pid[i] - base, exp_pid[i] - base);
        check($sformatf("%s/ch_idx%0d", tag, i), obs_pch[i], exp_pch[i]);
      end
      check({tag, "/idle_at"}, idle_seen - base, exp_idle - base);
      check({tag, "/err"}, err, exp_err);
      check({tag, "/err_code"}, err_code, exp_code);
      check({tag, "/ovr"}, ovr, exp_ovr);
      check({tag, "/glitches"}, glitches, 0);
    end
  endtask

  initial begin
    rst = 1'b1; stp = 1'b0; abrt = 1'b0; cont = 1'b0; eoSEN = '0; eoPID = 1'b0;
    period = '0; timeout = '0;
    #12;
    check("reset/outputs", {stSEN, h, stPID, ena, eop}, 1);
    check("reset/flags", {err, err_code, ovr, ch_idx}, 0);
    @(negedge clk);
    rst = 1'b0;

    set_cfg(40, 0, 1, 3, 5, 2, 2, -1, 0);   run_seq("single");
    set_cfg(40, 0, 3, 3, 5, 2, 2, -1, 0);   run_seq("cont3");
    set_cfg(40, 8, 1, 2, -1, 2, 2, -1, 0);  run_seq("sen_timeout");
    set_cfg(10, 0, 2, 1, 1, 6, 6, -1, 0);   run_seq("overrun");
    set_cfg(10, 0, 3, 1, 1, 6, 6, 30, 0);   run_seq("abort_pid1");
    set_cfg(30, 4, 1, 4, 0, 4, 4, -1, 0);   run_seq("tmo_tie");
    set_cfg(50, 5, 1, 1, 1, 2, 6, -1, 0);   run_seq("pid_timeout");
    set_cfg(0, 0, 2, 1, 2, 1, 3, -1, 0);    run_seq("period0");
    set_cfg(3, 0, 5, 3, 3, 1, 1, 12, 1);    run_seq("rst_wait_sen");

    for (int r = 0; r < 24; r++) begin
      cfg_period = $urandom_range(60, 0);
      cfg_tmo    = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(20, 3);
      cfg_nper   = $urandom_range(3, 1);
      for (int i = 0; i < N_CH; i++) begin
        sdel[i] = $urandom_range(12, 0);
        if (cfg_tmo != 0 && $urandom_range(7, 0) == 0) sdel[i] = -1;
        pdel[i] = $urandom_range(14, 1);
      end
      cfg_cut_rel = ($urandom_range(5, 0) == 0) ? $urandom_range(40, 0) : -1;
      cfg_is_rst  = 1'b0;
      run_seq($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
